// File: rtl/spi_slave_frontend.sv
// SPI slave front end (mode 0, MSB first) that turns host frames into single-cycle
// register-bank accesses and returns read data on miso.
//
// Frame: 1 R/W bit (1 = read) + ALINES address bits, then DWIDTH data bits.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   sclk, cs_n, mosi  SPI pins from the host (asynchronous, oversampled)
//   miso, miso_oe   SPI read data and its tri-state enable
//   cs, wr, rd      single-cycle bank access strobes
//   addr, din       registered bank address and write data
//   dout            bank read data, valid the cycle after rd
//   frame_err       one-cycle pulse when a frame is aborted
module spi_slave_frontend #(
    parameter int unsigned DWIDTH      = 16,
    parameter int unsigned ALINES      = 7,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic              cs,
    output logic              wr,
    output logic              rd,
    output logic [ALINES-1:0] addr,
    output logic [DWIDTH-1:0] din,
    input  logic [DWIDTH-1:0] dout,
    output logic              frame_err
);

    localparam int unsigned HdrBits = ALINES + 1;
    localparam int unsigned MaxBits = (HdrBits > DWIDTH) ? HdrBits : DWIDTH;
    localparam int unsigned CntW    = $clog2(MaxBits + 1);

    typedef enum logic [2:0] {
        StIdle, StHdr, StRdReq, StRdLoad, StData, StWrCommit, StDone
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_n_sync_q, mosi_sync_q, ready_q;
    logic                   sclk_s, cs_n_s, mosi_s;
    logic                   sclk_prev_q, cs_n_prev_q, armed_q;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [HdrBits-1:0]  hdr_q, hdr_d, hdr_full;
    logic [DWIDTH-1:0]   rx_q, rx_d, rx_full;
    logic [DWIDTH-1:0]   tx_q, tx_d;
    logic                rd_frame_q, rd_frame_d;
    logic [ALINES-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]   din_q, din_d;
    logic                frame_err_q, frame_err_d;

    // Synchronizers. ready_q fills with ones so that the synced pins are known to
    // carry real samples (not reset values) once its top bit is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_n_sync_q <= '1;
            mosi_sync_q <= '0;
            ready_q     <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            ready_q     <= {ready_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_n_s = cs_n_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // armed_q stays low until cs_n has been seen high after reset, so a cs_n that
    // was already low at reset release never starts a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_prev_q <= 1'b0;
            cs_n_prev_q <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            cs_n_prev_q <= cs_n_s;
            armed_q     <= armed_q | (ready_q[SYNC_STAGES-1] & cs_n_s);
        end
    end

    assign sclk_rise = ~cs_n_s & sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~cs_n_s & ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_n_s & ~cs_n_prev_q;
    assign cs_fall   = armed_q & ~cs_n_s & cs_n_prev_q;

    assign hdr_full = {hdr_q[HdrBits-2:0], mosi_s};
    assign rx_full  = {rx_q[DWIDTH-2:0], mosi_s};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hdr_d       = hdr_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        rd_frame_d  = rd_frame_q;
        addr_d      = addr_q;
        din_d       = din_q;
        frame_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d = StHdr;
                    cnt_d   = '0;
                end
            end
            StHdr: begin
                if (cs_rise) begin
                    state_d     = StIdle;
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    hdr_d = hdr_full;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(HdrBits - 1)) begin
                        addr_d     = hdr_full[ALINES-1:0];
                        rd_frame_d = hdr_full[HdrBits-1];
                        cnt_d      = '0;
                        state_d    = hdr_full[HdrBits-1] ? StRdReq : StData;
                    end
                end
            end
            StRdReq: begin
                if (cs_rise) begin
                    state_d     = StIdle;
                    frame_err_d = 1'b1;
                end else begin
                    state_d = StRdLoad;
                end
            end
            StRdLoad: begin
                if (cs_rise) begin
                    state_d     = StIdle;
                    frame_err_d = 1'b1;
                end else begin
                    tx_d    = dout;
                    state_d = StData;
                end
            end
            StData: begin
                if (cs_rise) begin
                    state_d     = StIdle;
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (!rd_frame_q) begin
                        rx_d = rx_full;
                    end
                    if (cnt_q == CntW'(DWIDTH - 1)) begin
                        if (rd_frame_q) begin
                            state_d = StDone;
                        end else begin
                            din_d   = rx_full;
                            state_d = StWrCommit;
                        end
                    end
                end else if (sclk_fall && rd_frame_q && (cnt_q != '0)) begin
                    // The first fall after the header only presents the MSB.
                    tx_d = {tx_q[DWIDTH-2:0], 1'b0};
                end
            end
            StWrCommit: begin
                state_d = cs_n_s ? StIdle : StDone;
            end
            StDone: begin
                if (cs_n_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hdr_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            rd_frame_q  <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hdr_q       <= hdr_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            rd_frame_q  <= rd_frame_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            frame_err_q <= frame_err_d;
        end
    end

    // In RdLoad the tx register is being loaded this cycle, so present dout directly.
    always_comb begin
        miso = 1'b0;
        if (state_q == StRdLoad) begin
            miso = dout[DWIDTH-1];
        end else if ((state_q == StData) && rd_frame_q) begin
            miso = tx_q[DWIDTH-1];
        end
    end

    assign miso_oe   = ~cs_n_s;
    assign rd        = (state_q == StRdReq);
    assign wr        = (state_q == StWrCommit);
    assign cs        = rd | wr;
    assign addr      = addr_q;
    assign din       = din_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_frontend.sv
// Self-checking bench for spi_slave_frontend: drives SPI frames from a host task,
// keeps a register-bank stub on the access port, and checks accesses, miso bits
// and frame_err against a frame-level model.
module tb_spi_slave_frontend;

    localparam int H = 5;  // sclk half period in clk cycles

    typedef struct packed {
        logic        is_wr;
        logic [6:0]  addr;
        logic [15:0] data;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst, sclk, cs_n, mosi;
    logic        miso, miso_oe, cs, wr, rd, frame_err;
    logic [6:0]  addr;
    logic [15:0] din, dout;

    int n_tests = 0;
    int n_fail  = 0;
    int err_seen = 0;
    int wr_seen  = 0;
    int rd_seen  = 0;
    logic [6:0]  last_wr_addr;
    logic [15:0] last_wr_din;
    logic [15:0] bank [128];
    logic [15:0] model_mem [128];
    acc_t        exp_q [$];
    acc_t        mon_e;

    spi_slave_frontend #(
        .DWIDTH     (16),
        .ALINES     (7),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .cs       (cs),
        .wr       (wr),
        .rd       (rd),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Register-bank stub: writes on cs&wr, registered read data the cycle after rd.
    always @(posedge clk) begin
        if (cs && wr) bank[addr] <= din;
        if (cs && rd) dout <= bank[addr];
    end

    // Compare process: every access must be the next one the model expects.
    always @(negedge clk) begin
        if (rst) begin
            check("reset_outputs", {3'b0, cs, wr, rd, addr, din, miso, miso_oe, frame_err}, 32'h0);
        end else begin
            if (frame_err) err_seen++;
            if (cs || wr || rd) begin
                check("strobe_shape", {31'b0, cs && (wr ^ rd)}, 32'h1);
                if (wr) begin
                    wr_seen++;
                    last_wr_addr = addr;
                    last_wr_din  = din;
                end
                if (rd) rd_seen++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_access: got wr=%0b rd=%0b addr=0x%0h, required none",
                             wr, rd, addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("acc_kind", {31'b0, wr}, {31'b0, mon_e.is_wr});
                    check("acc_addr", {25'b0, addr}, {25'b0, mon_e.addr});
                    if (mon_e.is_wr) check("acc_din", {16'b0, din}, {16'b0, mon_e.data});
                end
            end
        end
    end

    // Host side of one frame; returns the miso bit sampled before each rise.
    task automatic spi_frame(input int nbits, input logic [31:0] bits, input bit do_cs,
                             input bit end_cs, input int gap, output logic [31:0] got);
        got = '0;
        if (do_cs) begin
            @(posedge clk); #1 cs_n = 1'b0;
        end
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < nbits; k++) begin
            mosi = bits[nbits-1-k];
            repeat (H) @(posedge clk);
            #1;
            got = {got[30:0], miso};
            check("miso_oe_active", {31'b0, miso_oe}, 32'h1);
            sclk = 1'b1;
            repeat (H) @(posedge clk);
            #1 sclk = 1'b0;
        end
        mosi = 1'b0;
        if (end_cs) begin
            repeat (H) @(posedge clk);
            #1 cs_n = 1'b1;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    // Frame-level model: derive accesses, miso bits and frame_err from the bit list.
    task automatic run_frame(input int nbits, input logic [31:0] bits, input bit do_cs,
                             input int gap, output logic [31:0] got);
        logic [7:0]  hdr;
        logic [15:0] data;
        logic [15:0] rv;
        logic [31:0] exp_miso;
        logic        b;
        int          err0;
        hdr = '0;
        data = '0;
        exp_miso = '0;
        for (int k = 0; k < nbits; k++) begin
            b = bits[nbits-1-k];
            if (k < 8) hdr = {hdr[6:0], b};
            else if (k < 24) data = {data[14:0], b};
        end
        rv = model_mem[hdr[6:0]];
        for (int k = 0; k < nbits; k++) begin
            b = (do_cs && nbits >= 8 && hdr[7] && k >= 8 && k < 24) ? rv[23-k] : 1'b0;
            exp_miso = {exp_miso[30:0], b};
        end
        if (do_cs && nbits >= 8 && hdr[7]) begin
            exp_q.push_back('{is_wr: 1'b0, addr: hdr[6:0], data: 16'h0});
        end else if (do_cs && nbits >= 24) begin
            exp_q.push_back('{is_wr: 1'b1, addr: hdr[6:0], data: data});
            model_mem[hdr[6:0]] = data;
        end
        err0 = err_seen;
        spi_frame(nbits, bits, do_cs, 1'b1, gap, got);
        check("frame_err_count", err_seen - err0, (do_cs && nbits < 24) ? 32'h1 : 32'h0);
        check("pending_acc", exp_q.size(), 32'h0);
        exp_q.delete();
        check("miso_bits", got, exp_miso);
        if (gap >= 4) check("miso_oe_idle", {31'b0, miso_oe}, 32'h0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, required finish before 5 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] bits;
        int wr0, rd0, err0, nb;
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; dout = '0;
        for (int i = 0; i < 128; i++) begin
            bank[i] = 16'($urandom);
            model_mem[i] = bank[i];
        end
        bank[1] = 16'h5AA5;
        model_mem[1] = 16'h5AA5;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Write 0x03 <= 0xBEEF
        wr0 = wr_seen; rd0 = rd_seen;
        run_frame(24, {8'h0, 8'h03, 16'hBEEF}, 1'b1, 12, got);
        check("wr_once", wr_seen - wr0, 32'h1);
        check("wr_no_rd", rd_seen - rd0, 32'h0);
        check("wr_addr_lit", {25'b0, last_wr_addr}, 32'h3);
        check("wr_din_lit", {16'b0, last_wr_din}, 32'hBEEF);

        // Read 0x01 -> 0x5AA5
        rd0 = rd_seen;
        run_frame(24, {8'h0, 8'h81, 16'h0}, 1'b1, 12, got);
        check("rd_once", rd_seen - rd0, 32'h1);
        check("rd_miso_lit", {16'b0, got[15:0]}, 32'h0000_5AA5);

        // Abort after 4 data bits, then a clean write to the same address
        wr0 = wr_seen;
        run_frame(12, {20'h0, 8'h05, 4'hA}, 1'b1, 12, got);
        check("abort_no_wr", wr_seen - wr0, 32'h0);
        run_frame(24, {8'h0, 8'h05, 16'h1234}, 1'b1, 12, got);
        check("after_abort_bank", {16'b0, bank[5]}, 32'h1234);

        // Back-to-back write then read with a minimal cs_n gap
        run_frame(24, {8'h0, 8'h02, 16'hA5A5}, 1'b1, 2, got);
        run_frame(24, {8'h0, 8'h82, 16'h0}, 1'b1, 12, got);
        check("b2b_read_lit", {16'b0, got[15:0]}, 32'h0000_A5A5);

        // 30 sclk cycles in a write frame
        wr0 = wr_seen;
        run_frame(30, {2'b0, 8'h0A, 16'hC3C3, 6'h2D}, 1'b1, 12, got);
        check("extra_wr_once", wr_seen - wr0, 32'h1);
        check("extra_din_lit", {16'b0, last_wr_din}, 32'hC3C3);

        // Reset after 10 bits of a write
        wr0 = wr_seen; err0 = err_seen;
        spi_frame(10, {22'h0, 8'h07, 2'b10}, 1'b1, 1'b0, 0, got);
        #2 rst = 1'b1;
        #1 check("rst_async", {3'b0, cs, wr, rd, addr, din, miso, miso_oe, frame_err}, 32'h0);
        cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("rst_no_wr", wr_seen - wr0, 32'h0);
        check("rst_no_err", err_seen - err0, 32'h0);
        run_frame(24, {8'h0, 8'h07, 16'h0F0F}, 1'b1, 12, got);
        check("post_rst_bank", {16'b0, bank[7]}, 32'h0F0F);

        // cs_n already low at reset release must be ignored until it rises again
        cs_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wr0 = wr_seen;
        run_frame(24, {8'h0, 8'h04, 16'h7777}, 1'b0, 12, got);
        check("low_at_release_no_wr", wr_seen - wr0, 32'h0);
        run_frame(24, {8'h0, 8'h04, 16'h1111}, 1'b1, 12, got);
        run_frame(24, {8'h0, 8'h84, 16'h0}, 1'b1, 12, got);
        check("low_at_release_rd_lit", {16'b0, got[15:0]}, 32'h0000_1111);

        // Randomized frames, including aborted and over-long ones
        for (int i = 0; i < 24; i++) begin
            bits = $urandom;
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32)) : 24;
            run_frame(nb, bits, 1'b1, (nb < 24) ? 12 : int'($urandom_range(2, 12)), got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
